wb_csr_bank: RTL and testbench
==============================

// Module: wb_csr_bank
// PURPOSE
//  Parametrised Wishbone-pipelined CSR bank; generalises the fixed 8-bit read-only build-info table.
//  Adds configurable bus width, N read/write control words and N read-only status words.
//  Adds a write-1-to-clear interrupt status register with an enable mask and an interrupt output.
//  Sits behind the SiTCP RBCP-to-Wishbone bridge as one slave; one outstanding transaction at a time.
// PARAMETERS
//  ADDRESS_WIDTH     8      Wishbone byte-address width
//  DATA_WIDTH        8      bus/register width: 8, 16 or 32; BYTES = DATA_WIDTH/8
//  BASE_ADDRESS      0      byte base of the bank; decoded span = 2**LOCAL_AW bytes
//  LOCAL_AW          6      local byte-address width (bank size)
//  N_CTRL            4      number of RW control words (1..16)
//  N_STAT            4      number of RO status words (1..16)
//  ERROR_STATUS      0      1: bad access answers ERR; 0: answers ACK
//  DEFAULT_READ_DATA 0      read data returned for a bad access
//  VERSION           0      constant shown in word 0 (DATA_WIDTH bits)
// PORTS
//  i_clk        in   1                 clock
//  i_rst_n      in   1                 asynchronous active-low reset
//  i_wb_cyc     in   1                 bus cycle
//  i_wb_stb     in   1                 request strobe
//  o_wb_stall   out  1                 1 = request not accepted this cycle
//  i_wb_adr     in   ADDRESS_WIDTH     byte address
//  i_wb_we      in   1                 1 = write
//  i_wb_dat     in   DATA_WIDTH        write data
//  i_wb_sel     in   BYTES             byte-lane enables
//  o_wb_ack     out  1                 good completion, 1-cycle pulse
//  o_wb_err     out  1                 error completion, 1-cycle pulse
//  o_wb_rty     out  1                 tied 0
//  o_wb_dat     out  DATA_WIDTH        read data, valid with ack/err
//  o_ctrl       out  N_CTRL*DATA_WIDTH control words, word k at [k*DW+:DW]
//  i_stat       in   N_STAT*DATA_WIDTH status words, sampled at read acceptance
//  i_irq_event  in   DATA_WIDTH        per-bit set pulses into IRQ_STATUS
//  o_irq        out  1                 registered |(IRQ_STATUS & IRQ_EN)
// BEHAVIOUR
//  Map (word index w = local byte addr / BYTES):
//   w0 VERSION (RO); w1 IRQ_STATUS (W1C); w2 IRQ_EN (RW);
//   w3..w3+N_CTRL-1 CTRL (RW); next N_STAT words STAT (RO).
//  Accept = i_wb_cyc & i_wb_stb & !o_wb_stall.
//  FSM IDLE->RESP on accept; RESP->IDLE next cycle. o_wb_stall = (state==RESP).
//  Response: exactly one of ack/err pulses in the cycle after accept; o_wb_dat registered at accept.
//  Bad access:
//   - address outside [BASE_ADDRESS, BASE_ADDRESS+2**LOCAL_AW);
//   - local addr not BYTES-aligned;
//   - unmapped word;
//   - write to VERSION/STAT.
//   Handling: no state change; read data = DEFAULT_READ_DATA; err if ERROR_STATUS else ack.
//  Writes are per byte lane: only lanes with i_wb_sel=1 are updated. All-zero sel is a legal no-op and is acked.
//  Reads ignore i_wb_sel and return the full word.
//  IRQ_STATUS next = (cur & ~(w1c_mask)) | i_irq_event; w1c_mask = data&lane mask on a W1C write.
//   Same-bit set and clear in one cycle: set wins.
//  o_irq updates the cycle after IRQ_STATUS/IRQ_EN change (1-cycle latency).
//  i_wb_cyc low in RESP: the pending ack/err is suppressed, but a write already accepted still takes effect.
//  Reset (async, any time, including mid-transaction):
//   state=IDLE; stall/ack/err/rty=0; o_wb_dat=0; o_ctrl=0; IRQ_STATUS=0; IRQ_EN=0; o_irq=0.
// TESTING
//  1 DW=32,BASE=0: read byte addr 0x00 -> ack at accept+1, dat=VERSION; stall high exactly 1 cycle.
//  2 Write 0xA5A5A5A5 sel=4'b0101 to CTRL0 (0x0C) after CTRL0=0 -> o_ctrl[31:0]=0x00A500A5, ack; readback equal.
//  3 Pulse i_irq_event=0x3, IRQ_EN=0x1 -> o_irq=1 one cycle later.
//    Write 0x1 to 0x04 in the same cycle as event bit0 -> bit0 stays 1.
//    Write 0x1 again with no event -> IRQ_STATUS=0x2, o_irq=0.
//  4 ERROR_STATUS=1: write to STAT0, read at 0x02 (misaligned), read beyond map -> err each,
//    dat=DEFAULT_READ_DATA, no state change. ERROR_STATUS=0: same accesses -> ack.
//  5 Back-to-back stb held high for 4 requests -> accepted every other cycle, 4 acks, none lost or duplicated.
//  6 Assert i_rst_n=0 in RESP after a CTRL write -> ack suppressed, all outputs 0; first post-reset read returns CTRL=0.

Source files
------------

// File: rtl/wb_csr_bank.sv
// ---------------------------------------------------------------------------
// wb_csr_bank
//
// Parametrised control/status register bank on a pipelined Wishbone slave
// port. It holds one constant version word, a write-1-to-clear interrupt
// status word with an enable mask, N_CTRL read/write control words and
// N_STAT read-only status words. Only one transaction is ever in flight: the
// slave stalls for the single response cycle that follows every accepted
// request.
//
// Word map (word index = local byte address / BYTES):
//   0                  VERSION      read-only constant
//   1                  IRQ_STATUS   write-1-to-clear, set by i_irq_event
//   2                  IRQ_EN       read/write interrupt enable mask
//   3 .. 3+N_CTRL-1    CTRL         read/write control words
//   next N_STAT words  STAT         read-only, sampled from i_stat
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_wb_cyc, i_wb_stb      Wishbone cycle and request strobe
//   o_wb_stall              request not accepted this cycle
//   i_wb_adr                byte address
//   i_wb_we                 1 = write
//   i_wb_dat, i_wb_sel      write data and byte-lane enables
//   o_wb_ack, o_wb_err      one-cycle completion pulses
//   o_wb_rty                never asserted
//   o_wb_dat                read data, valid with ack/err
//   o_ctrl                  control words, word k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_stat                  status words, word k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_irq_event             per-bit set pulses into IRQ_STATUS
//   o_irq                   registered |(IRQ_STATUS & IRQ_EN)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module wb_csr_bank #(
   parameter int                    ADDRESS_WIDTH     = 8,
   parameter int                    DATA_WIDTH        = 8,
   parameter longint unsigned       BASE_ADDRESS      = 0,
   parameter int                    LOCAL_AW          = 6,
   parameter int                    N_CTRL            = 4,
   parameter int                    N_STAT            = 4,
   parameter int                    ERROR_STATUS      = 0,
   parameter logic [DATA_WIDTH-1:0] DEFAULT_READ_DATA = '0,
   parameter logic [DATA_WIDTH-1:0] VERSION           = '0
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_wb_cyc,
   input  logic                         i_wb_stb,
   output logic                         o_wb_stall,
   input  logic [ADDRESS_WIDTH-1:0]     i_wb_adr,
   input  logic                         i_wb_we,
   input  logic [DATA_WIDTH-1:0]        i_wb_dat,
   input  logic [DATA_WIDTH/8-1:0]      i_wb_sel,
   output logic                         o_wb_ack,
   output logic                         o_wb_err,
   output logic                         o_wb_rty,
   output logic [DATA_WIDTH-1:0]        o_wb_dat,
   output logic [N_CTRL*DATA_WIDTH-1:0] o_ctrl,
   input  logic [N_STAT*DATA_WIDTH-1:0] i_stat,
   input  logic [DATA_WIDTH-1:0]        i_irq_event,
   output logic                         o_irq
);

   localparam int          BYTES        = DATA_WIDTH / 8;
   localparam int          ALIGN_BITS   = $clog2(BYTES);
   localparam logic [63:0] C_BASE       = BASE_ADDRESS;
   localparam logic [63:0] C_SPAN       = 64'd1 << LOCAL_AW;
   localparam logic [63:0] C_ALIGN_MASK = 64'(BYTES - 1);
   localparam logic        C_ERR_RESP   = (ERROR_STATUS != 0);

   typedef enum logic {
      S_IDLE,
      S_RESP
   } state_t;

   state_t                r_state;
   logic                  r_ack;
   logic                  r_err;
   logic [DATA_WIDTH-1:0] r_dat;
   logic                  r_irq;
   logic [DATA_WIDTH-1:0] r_irqStatus;
   logic [DATA_WIDTH-1:0] r_irqEn;
   logic [DATA_WIDTH-1:0] r_ctrl [N_CTRL];

   logic [64:0]           w_diff;
   logic [63:0]           w_local;
   logic [63:0]           w_word;
   logic                  w_inRange;
   logic                  w_aligned;
   logic                  w_isVersion;
   logic                  w_isIrqStatus;
   logic                  w_isIrqEn;
   logic [N_CTRL-1:0]     w_ctrlSel;
   logic [N_STAT-1:0]     w_statSel;
   logic                  w_mapped;
   logic                  w_bad;
   logic [DATA_WIDTH-1:0] w_rdData;
   logic [DATA_WIDTH-1:0] w_laneMask;
   logic [DATA_WIDTH-1:0] w_w1cMask;
   logic                  w_accept;
   logic                  w_write;

   // Merge new write data into an existing word, byte lane by byte lane.
   function automatic logic [DATA_WIDTH-1:0] laneMerge(
      input logic [DATA_WIDTH-1:0] oldVal,
      input logic [DATA_WIDTH-1:0] newVal,
      input logic [DATA_WIDTH-1:0] mask
   );
      return (oldVal & ~mask) | (newVal & mask);
   endfunction

   // Address decode. The subtraction is one bit wider than the address so
   // that the borrow tells us the address lies below the bank base; the
   // remaining range, alignment and word checks then work on the local offset.
   always_comb begin
      w_diff        = {1'b0, 64'(i_wb_adr)} - {1'b0, C_BASE};
      w_local       = w_diff[63:0];
      w_inRange     = !w_diff[64] && (w_local < C_SPAN);
      w_aligned     = ((w_local & C_ALIGN_MASK) == 64'd0);
      w_word        = w_local >> ALIGN_BITS;
      w_isVersion   = (w_word == 64'd0);
      w_isIrqStatus = (w_word == 64'd1);
      w_isIrqEn     = (w_word == 64'd2);
      w_ctrlSel     = '0;
      w_statSel     = '0;
      for (int k = 0; k < N_CTRL; k++) begin
         w_ctrlSel[k] = (w_word == 64'(3 + k));
      end
      for (int k = 0; k < N_STAT; k++) begin
         w_statSel[k] = (w_word == 64'(3 + N_CTRL + k));
      end
      w_mapped = w_isVersion | w_isIrqStatus | w_isIrqEn | (|w_ctrlSel) | (|w_statSel);
      w_bad    = !w_inRange || !w_aligned || !w_mapped ||
                 (i_wb_we && (w_isVersion || (|w_statSel)));
   end

   // Read multiplexer. Selects are one-hot for a good access, so OR-ing the
   // gated words is enough; a bad access never uses this value.
   always_comb begin
      w_rdData = '0;
      if (w_isVersion) begin
         w_rdData = w_rdData | VERSION;
      end
      if (w_isIrqStatus) begin
         w_rdData = w_rdData | r_irqStatus;
      end
      if (w_isIrqEn) begin
         w_rdData = w_rdData | r_irqEn;
      end
      for (int k = 0; k < N_CTRL; k++) begin
         if (w_ctrlSel[k]) begin
            w_rdData = w_rdData | r_ctrl[k];
         end
      end
      for (int k = 0; k < N_STAT; k++) begin
         if (w_statSel[k]) begin
            w_rdData = w_rdData | i_stat[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Expand the byte enables into a bit mask and derive the write-1-to-clear
   // mask; the clear mask is only live on a good write to IRQ_STATUS.
   always_comb begin
      w_laneMask = '0;
      for (int b = 0; b < BYTES; b++) begin
         w_laneMask[b*8 +: 8] = {8{i_wb_sel[b]}};
      end
      w_accept  = i_wb_cyc && i_wb_stb && (r_state == S_IDLE);
      w_write   = w_accept && i_wb_we && !w_bad;
      w_w1cMask = (w_write && w_isIrqStatus) ? (i_wb_dat & w_laneMask) : '0;
   end

   // Bus handshake FSM. A request is accepted only in IDLE; the response is
   // registered at acceptance and presented during the single RESP cycle,
   // which also holds the stall. Good writes return zero data.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_dat   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_ack <= 1'b0;
               r_err <= 1'b0;
               if (w_accept) begin
                  r_state <= S_RESP;
                  if (w_bad) begin
                     r_dat <= DEFAULT_READ_DATA;
                     r_ack <= !C_ERR_RESP;
                     r_err <= C_ERR_RESP;
                  end else begin
                     r_dat <= i_wb_we ? '0 : w_rdData;
                     r_ack <= 1'b1;
                     r_err <= 1'b0;
                  end
               end
            end
            S_RESP: begin
               r_state <= S_IDLE;
               r_ack   <= 1'b0;
               r_err   <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_ack   <= 1'b0;
               r_err   <= 1'b0;
            end
         endcase
      end
   end

   // Register file. Writes land on the acceptance edge, so an accepted write
   // survives a master that drops cyc before its ack. Interrupt events are
   // OR-ed in after the clear so a simultaneous set wins. o_irq is a
   // registered view of the masked status, one cycle behind it.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_irqStatus <= '0;
         r_irqEn     <= '0;
         r_irq       <= 1'b0;
         for (int k = 0; k < N_CTRL; k++) begin
            r_ctrl[k] <= '0;
         end
      end else begin
         r_irqStatus <= (r_irqStatus & ~w_w1cMask) | i_irq_event;
         r_irq       <= |(r_irqStatus & r_irqEn);
         if (w_write && w_isIrqEn) begin
            r_irqEn <= laneMerge(r_irqEn, i_wb_dat, w_laneMask);
         end
         for (int k = 0; k < N_CTRL; k++) begin
            if (w_write && w_ctrlSel[k]) begin
               r_ctrl[k] <= laneMerge(r_ctrl[k], i_wb_dat, w_laneMask);
            end
         end
      end
   end

   // A completion is withheld if the master has abandoned the cycle.
   assign o_wb_ack   = r_ack && i_wb_cyc;
   assign o_wb_err   = r_err && i_wb_cyc;
   assign o_wb_rty   = 1'b0;
   assign o_wb_stall = (r_state == S_RESP);
   assign o_wb_dat   = r_dat;
   assign o_irq      = r_irq;

   for (genvar g = 0; g < N_CTRL; g++) begin : g_ctrlOut
      assign o_ctrl[g*DATA_WIDTH +: DATA_WIDTH] = r_ctrl[g];
   end

endmodule

// File: tb/tb_wb_csr_bank.sv
// ---------------------------------------------------------------------------
// tb_wb_csr_bank
//
// Directed bench for wb_csr_bank with a 32-bit bus. Two instances share one
// bus: "A" answers bad accesses with ERR, "B" answers them with ACK. Every
// request pushes its expected completion onto a scoreboard queue, and each
// completion seen on the bus pops and compares one entry.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_wb_csr_bank;

   localparam int          AW  = 8;
   localparam int          DW  = 32;
   localparam int          NC  = 4;
   localparam int          NS  = 4;
   localparam logic [31:0] VER = 32'h1234_5678;
   localparam logic [31:0] DEF = 32'hDEAD_BEEF;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           cyc, stb, we;
   logic [AW-1:0]  adr;
   logic [DW-1:0]  datIn;
   logic [3:0]     sel;
   logic [NS*DW-1:0] stat;
   logic [DW-1:0]  irqEv;

   logic           stallA, ackA, errA, rtyA, irqA;
   logic [DW-1:0]  datA;
   logic [NC*DW-1:0] ctrlA;
   logic           stallB, ackB, errB, rtyB, irqB;
   logic [DW-1:0]  datB;
   logic [NC*DW-1:0] ctrlB;

   typedef struct {
      string       tag;
      logic        isErr;
      logic        chkDat;
      logic [31:0] dat;
   } exp_t;

   exp_t        expQ[$];
   int          nVec = 0;
   int          nErr = 0;
   logic [31:0] expCtrl [NC];

   logic        rqWe  [4];
   logic [7:0]  rqAdr [4];
   logic [31:0] rqDat [4];
   logic [31:0] rqExp [4];

   always #5 clk = ~clk;

   wb_csr_bank #(
      .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDRESS(0), .LOCAL_AW(6),
      .N_CTRL(NC), .N_STAT(NS), .ERROR_STATUS(1),
      .DEFAULT_READ_DATA(DEF), .VERSION(VER)
   ) dutA (
      .i_clk(clk), .i_rst_n(rst_n), .i_wb_cyc(cyc), .i_wb_stb(stb),
      .o_wb_stall(stallA), .i_wb_adr(adr), .i_wb_we(we), .i_wb_dat(datIn),
      .i_wb_sel(sel), .o_wb_ack(ackA), .o_wb_err(errA), .o_wb_rty(rtyA),
      .o_wb_dat(datA), .o_ctrl(ctrlA), .i_stat(stat), .i_irq_event(irqEv),
      .o_irq(irqA)
   );

   wb_csr_bank #(
      .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDRESS(0), .LOCAL_AW(6),
      .N_CTRL(NC), .N_STAT(NS), .ERROR_STATUS(0),
      .DEFAULT_READ_DATA(DEF), .VERSION(VER)
   ) dutB (
      .i_clk(clk), .i_rst_n(rst_n), .i_wb_cyc(cyc), .i_wb_stb(stb),
      .o_wb_stall(stallB), .i_wb_adr(adr), .i_wb_we(we), .i_wb_dat(datIn),
      .i_wb_sel(sel), .o_wb_ack(ackB), .o_wb_err(errB), .o_wb_rty(rtyB),
      .o_wb_dat(datB), .o_ctrl(ctrlB), .i_stat(stat), .i_irq_event(irqEv),
      .o_irq(irqB)
   );

   // One comparison: counts it, and on a miscompare counts and reports it.
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      nVec++;
      assert (obs === exp) else begin
         nErr++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] ctrlModel();
      logic [127:0] v;
      for (int k = 0; k < NC; k++) begin
         v[k*32 +: 32] = expCtrl[k];
      end
      return v;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] oldVal, input logic [31:0] newVal,
                                         input logic [3:0] s);
      logic [31:0] m;
      for (int b = 0; b < 4; b++) begin
         m[b*8 +: 8] = {8{s[b]}};
      end
      return (oldVal & ~m) | (newVal & m);
   endfunction

   // Pops the oldest expected completion and compares it against the bus.
   task automatic checkOutput(input int waitCnt);
      exp_t e;
      chk("sbNotEmpty", 128'(expQ.size() > 0), 128'd1);
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         chk({e.tag, "-latency"}, 128'(waitCnt), 128'd0);
         chk({e.tag, "-ackA"}, 128'(ackA), 128'(!e.isErr));
         chk({e.tag, "-errA"}, 128'(errA), 128'(e.isErr));
         chk({e.tag, "-ackB"}, 128'(ackB), 128'd1);
         chk({e.tag, "-errB"}, 128'(errB), 128'd0);
         chk({e.tag, "-stallA"}, 128'(stallA), 128'd1);
         chk({e.tag, "-rty"}, 128'({rtyA, rtyB}), 128'd0);
         if (e.chkDat) begin
            chk({e.tag, "-datA"}, 128'(datA), 128'(e.dat));
            chk({e.tag, "-datB"}, 128'(datB), 128'(e.dat));
         end
      end
   endtask

   // Single transaction: present the request for one cycle, wait (bounded)
   // for the completion, then confirm the stall has dropped again.
   task automatic applyStimulus(input string tag, input logic w, input logic [7:0] a,
                                input logic [31:0] d, input logic [3:0] s, input logic expErr,
                                input logic chkDat, input logic [31:0] expDat,
                                input logic [31:0] ev);
      int waitCnt;
      expQ.push_back('{tag, expErr, chkDat, expDat});
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; datIn = d; sel = s; irqEv = ev;
      @(negedge clk);
      stb = 1'b0; irqEv = '0;
      waitCnt = 0;
      while (!(ackA || errA) && waitCnt < 8) begin
         @(negedge clk);
         waitCnt++;
      end
      checkOutput(waitCnt);
      cyc = 1'b0; we = 1'b0; sel = '0;
      @(negedge clk);
      chk({tag, "-stallLow"}, 128'(stallA), 128'd0);
   endtask

   task automatic driveReq(input int i);
      we = rqWe[i]; adr = rqAdr[i]; datIn = rqDat[i]; sel = 4'hF;
      expQ.push_back('{$sformatf("b2b%0d", i), 1'b0, !rqWe[i], rqExp[i]});
   endtask

   initial begin
      int idx, acks, iters;
      logic accNow;
      rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; datIn = '0;
      sel = '0; irqEv = '0;
      stat = {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
      for (int k = 0; k < NC; k++) expCtrl[k] = '0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rstStall", 128'({stallA, stallB}), 128'd0);
      chk("rstAck", 128'({ackA, ackB}), 128'd0);
      chk("rstErr", 128'({errA, errB}), 128'd0);
      chk("rstRty", 128'({rtyA, rtyB}), 128'd0);
      chk("rstDat", 128'(datA), 128'd0);
      chk("rstCtrl", 128'(ctrlA), 128'd0);
      chk("rstIrq", 128'({irqA, irqB}), 128'd0);
      rst_n = 1'b1;

      // Version read
      applyStimulus("rdVersion", 0, 8'h00, 0, 4'hF, 0, 1, VER, 0);

      // Lane-masked control writes and readback
      applyStimulus("wrCtrl0", 1, 8'h0C, 32'hA5A5A5A5, 4'b0101, 0, 0, 0, 0);
      expCtrl[0] = merge(expCtrl[0], 32'hA5A5A5A5, 4'b0101);
      chk("ctrl0Lanes", 128'(ctrlA[31:0]), 128'h00A500A5);
      chk("ctrlAfterW0", 128'(ctrlA), ctrlModel());
      applyStimulus("rdCtrl0", 0, 8'h0C, 0, 4'h0, 0, 1, 32'h00A500A5, 0);
      applyStimulus("wrCtrl3", 1, 8'h18, 32'hCAFEF00D, 4'hF, 0, 0, 0, 0);
      expCtrl[3] = 32'hCAFEF00D;
      applyStimulus("rdCtrl3", 0, 8'h18, 0, 4'hF, 0, 1, 32'hCAFEF00D, 0);
      applyStimulus("wrSelZero", 1, 8'h10, 32'hFFFFFFFF, 4'h0, 0, 0, 0, 0);
      chk("ctrlSelZero", 128'(ctrlA), ctrlModel());

      // Status reads
      applyStimulus("rdStat0", 0, 8'h1C, 0, 4'hF, 0, 1, 32'h1111_0001, 0);
      applyStimulus("rdStat3", 0, 8'h28, 0, 4'hF, 0, 1, 32'h4444_0004, 0);

      // Interrupts
      applyStimulus("wrIrqEn", 1, 8'h08, 32'h1, 4'hF, 0, 0, 0, 0);
      @(negedge clk); irqEv = 32'h3;
      @(negedge clk); irqEv = '0;
      chk("irqLatency0", 128'(irqA), 128'd0);
      @(negedge clk);
      chk("irqLatency1", 128'({irqA, irqB}), 128'b11);
      applyStimulus("rdIrqSt3", 0, 8'h04, 0, 4'hF, 0, 1, 32'h3, 0);
      applyStimulus("w1cSetWins", 1, 8'h04, 32'h1, 4'hF, 0, 0, 0, 32'h1);
      applyStimulus("rdIrqStSet", 0, 8'h04, 0, 4'hF, 0, 1, 32'h3, 0);
      chk("irqStillOn", 128'(irqA), 128'd1);
      applyStimulus("w1cClear", 1, 8'h04, 32'h1, 4'hF, 0, 0, 0, 0);
      applyStimulus("rdIrqSt2", 0, 8'h04, 0, 4'hF, 0, 1, 32'h2, 0);
      chk("irqOff", 128'({irqA, irqB}), 128'd0);

      // Bad accesses
      applyStimulus("wrStat0", 1, 8'h1C, 32'hFFFFFFFF, 4'hF, 1, 1, DEF, 0);
      applyStimulus("rdMisalign", 0, 8'h02, 0, 4'hF, 1, 1, DEF, 0);
      applyStimulus("rdUnmapped", 0, 8'h2C, 0, 4'hF, 1, 1, DEF, 0);
      applyStimulus("rdOutRange", 0, 8'h40, 0, 4'hF, 1, 1, DEF, 0);
      applyStimulus("wrMisalign", 1, 8'h0D, 32'h0, 4'hF, 1, 1, DEF, 0);
      applyStimulus("wrOutRange", 1, 8'h4C, 32'h0, 4'hF, 1, 1, DEF, 0);
      applyStimulus("wrVersion", 1, 8'h00, 32'h0, 4'hF, 1, 1, DEF, 0);
      applyStimulus("wrIrqMisal", 1, 8'h05, 32'hFFFFFFFF, 4'hF, 1, 1, DEF, 0);
      chk("badNoCtrlA", 128'(ctrlA), ctrlModel());
      chk("badNoCtrlB", 128'(ctrlB), ctrlModel());
      applyStimulus("rdIrqStKeep", 0, 8'h04, 0, 4'hF, 0, 1, 32'h2, 0);

      // Back-to-back requests with stb held high
      rqWe[0] = 1; rqAdr[0] = 8'h10; rqDat[0] = 32'h1111_1111; rqExp[0] = 0;
      rqWe[1] = 0; rqAdr[1] = 8'h10; rqDat[1] = 0;             rqExp[1] = 32'h1111_1111;
      rqWe[2] = 1; rqAdr[2] = 8'h14; rqDat[2] = 32'h2222_2222; rqExp[2] = 0;
      rqWe[3] = 0; rqAdr[3] = 8'h14; rqDat[3] = 0;             rqExp[3] = 32'h2222_2222;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; driveReq(0);
      idx = 0; acks = 0; iters = 0;
      while (acks < 4 && iters < 20) begin
         accNow = !stallA;
         @(negedge clk);
         iters++;
         if (ackA || errA) begin
            checkOutput(0);
            acks++;
         end
         if (accNow) begin
            idx++;
            if (idx < 4) driveReq(idx);
            else stb = 1'b0;
         end
      end
      chk("b2bAcks", 128'(acks), 128'd4);
      chk("b2bCycles", 128'(iters), 128'd7);
      @(negedge clk);
      chk("b2bNoExtra", 128'({ackA, errA, ackB, errB}), 128'd0);
      chk("b2bQueueEmpty", 128'(expQ.size()), 128'd0);
      cyc = 1'b0; we = 1'b0;
      expCtrl[1] = 32'h1111_1111; expCtrl[2] = 32'h2222_2222;
      chk("b2bCtrl", 128'(ctrlA), ctrlModel());

      // Reset in the middle of a write's response cycle
      applyStimulus("wrIrqEn3", 1, 8'h08, 32'h3, 4'hF, 0, 0, 0, 0);
      chk("irqBeforeRst", 128'(irqA), 128'd1);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'h0C; datIn = 32'hFFFFFFFF; sel = 4'hF;
      @(posedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      chk("midRstAck", 128'({ackA, ackB, errA, errB}), 128'd0);
      chk("midRstStall", 128'({stallA, stallB}), 128'd0);
      chk("midRstDat", 128'(datA), 128'd0);
      chk("midRstCtrl", 128'({ctrlA, ctrlB}), 128'd0);
      chk("midRstIrq", 128'({irqA, irqB}), 128'd0);
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < NC; k++) expCtrl[k] = '0;
      applyStimulus("postRstCtrl0", 0, 8'h0C, 0, 4'hF, 0, 1, 32'h0, 0);
      applyStimulus("postRstIrqEn", 0, 8'h08, 0, 4'hF, 0, 1, 32'h0, 0);
      applyStimulus("postRstIrqSt", 0, 8'h04, 0, 4'hF, 0, 1, 32'h0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: time limit reached, observed running expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
